// File: rtl/raster_dispatcher.sv
// Frame sequencer and round-robin triangle dispatcher feeding a bank of rasterizer units.
// Holds one triangle at a time and issues it to the next free unit after the last one granted.
module raster_dispatcher #(
    parameter int NUM_RAST     = 2,
    parameter int TRI_W        = 312,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_frame_start,
    input  logic                i_vtx_done,
    input  logic                i_tri_valid,
    input  logic [TRI_W-1:0]    i_tri_data,
    output logic                o_tri_busy,
    output logic [NUM_RAST-1:0] o_rast_valid,
    output logic [TRI_W-1:0]    o_rast_data,
    input  logic [NUM_RAST-1:0] i_rast_busy,
    output logic                o_frame_active,
    output logic                o_frame_done,
    output logic [15:0]         o_tri_count
);

    localparam int PTR_W = (NUM_RAST > 1) ? $clog2(NUM_RAST) : 1;
    localparam int QW    = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0]    QUIET_MAX = QW'(QUIET_CYCLES);
    localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(NUM_RAST - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_RAST-1:0] pend;
    logic                hold;
    logic                holdoff;
    logic [TRI_W-1:0]    hold_data;
    logic [QW-1:0]       quiet_cnt;

    logic                in_frame;
    logic                accept;
    logic                quiet;
    logic                units_idle;
    logic                issue;
    logic [NUM_RAST-1:0] free;
    logic [NUM_RAST-1:0] grant;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;

    assign in_frame   = (state == RUN) || (state == DRAIN);
    assign accept     = in_frame && i_tri_valid && !o_tri_busy && !holdoff;
    assign quiet      = i_vtx_done && !hold && !i_tri_valid;
    assign units_idle = (i_rast_busy == '0) && (pend == '0);
    // A unit that was just issued stays unavailable until it is seen raising busy.
    assign free       = ~i_rast_busy & ~pend;

    // Round-robin search starting one past the last granted unit.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        issue     = 1'b0;
        grant_idx = rr_ptr;
        grant     = '0;
        cand      = '0;
        if (in_frame && hold) begin
            for (int i = 1; i <= NUM_RAST; i++) begin
                cand = PTR_W'((int'(rr_ptr) + i) % NUM_RAST);
                if (!issue && free[cand]) begin
                    issue     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (issue) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            rr_ptr         <= LAST_UNIT;
            pend           <= '0;
            hold           <= 1'b0;
            holdoff        <= 1'b0;
            hold_data      <= '0;
            quiet_cnt      <= '0;
            o_tri_busy     <= 1'b1;
            o_rast_valid   <= '0;
            o_rast_data    <= '0;
            o_frame_active <= 1'b0;
            o_frame_done   <= 1'b0;
            o_tri_count    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
            o_rast_valid <= '0;
            o_frame_done <= 1'b0;
            holdoff      <= accept;
            pend         <= (pend & ~i_rast_busy) | grant;

            if (accept) begin
                hold      <= 1'b1;
                hold_data <= i_tri_data;
            end

            if (issue) begin
                hold         <= 1'b0;
                o_rast_valid <= grant;
                o_rast_data  <= hold_data;
                rr_ptr       <= grant_idx;
                if (o_tri_count != 16'hFFFF) begin
                    o_tri_count <= o_tri_count + 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    o_tri_busy <= 1'b1;
                    if (i_frame_start) begin
                        o_tri_count    <= '0;
                        o_frame_active <= 1'b1;
                        o_tri_busy     <= 1'b0;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    quiet_cnt  <= '0;
                    o_tri_busy <= accept || (hold && !issue);
                    if (i_vtx_done && !hold && !i_tri_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    o_tri_busy <= accept || (hold && !issue);
                    if (!quiet) begin
                        quiet_cnt <= '0;
                    end else if (quiet_cnt != QUIET_MAX) begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                    if (!i_vtx_done) begin
                        state <= RUN;
                    end else if (quiet && quiet_cnt == QUIET_MAX && units_idle) begin
                        state          <= DONE;
                        o_frame_done   <= 1'b1;
                        o_frame_active <= 1'b0;
                        o_tri_busy     <= 1'b1;
                    end
                end
                DONE: begin
                    o_tri_busy <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_dispatcher.sv
// Directed bench for raster_dispatcher: a small rasterizer model answers issue pulses with busy,
// and a monitor records every issue for comparison against hand-derived expectations.
module tb_raster_dispatcher;

    localparam int NUM_RAST     = 2;
    localparam int TRI_W        = 312;
    localparam int QUIET_CYCLES = 4;

    logic                i_clk         = 1'b0;
    logic                i_rst_n       = 1'b0;
    logic                i_frame_start = 1'b0;
    logic                i_vtx_done    = 1'b0;
    logic                i_tri_valid   = 1'b0;
    logic [TRI_W-1:0]    i_tri_data    = '0;
    logic                o_tri_busy;
    logic [NUM_RAST-1:0] o_rast_valid;
    logic [TRI_W-1:0]    o_rast_data;
    logic [NUM_RAST-1:0] i_rast_busy;
    logic                o_frame_active;
    logic                o_frame_done;
    logic [15:0]         o_tri_count;

    logic [NUM_RAST-1:0] force_busy = '0;
    logic [NUM_RAST-1:0] model_busy;
    logic [1:0]          busy_cnt [NUM_RAST];

    logic [NUM_RAST-1:0] issue_q [$];
    logic [TRI_W-1:0]    data_q  [$];

    int checks   = 0;
    int failures = 0;

    raster_dispatcher #(
        .NUM_RAST    (NUM_RAST),
        .TRI_W       (TRI_W),
        .QUIET_CYCLES(QUIET_CYCLES)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_vtx_done    (i_vtx_done),
        .i_tri_valid   (i_tri_valid),
        .i_tri_data    (i_tri_data),
        .o_tri_busy    (o_tri_busy),
        .o_rast_valid  (o_rast_valid),
        .o_rast_data   (o_rast_data),
        .i_rast_busy   (i_rast_busy),
        .o_frame_active(o_frame_active),
        .o_frame_done  (o_frame_done),
        .o_tri_count   (o_tri_count)
    );

    always #5 i_clk = ~i_clk;

    // Each unit raises busy the cycle after its issue pulse and holds it for two cycles.
    always @(posedge i_clk or negedge i_rst_n) begin
        for (int k = 0; k < NUM_RAST; k++) begin
            if (!i_rst_n)                 busy_cnt[k] <= 2'd0;
            else if (o_rast_valid[k])     busy_cnt[k] <= 2'd2;
            else if (busy_cnt[k] != 2'd0) busy_cnt[k] <= busy_cnt[k] - 2'd1;
        end
    end

    always_comb begin
        model_busy = '0;
        for (int k = 0; k < NUM_RAST; k++) model_busy[k] = (busy_cnt[k] != 2'd0);
    end

    assign i_rast_busy = model_busy | force_busy;

    always @(negedge i_clk) begin
        if (o_rast_valid != '0) begin
            issue_q.push_back(o_rast_valid);
            data_q.push_back(o_rast_data);
        end
    end

    task automatic check(input string tag, input logic [TRI_W-1:0] got, input logic [TRI_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [TRI_W-1:0] make_tri();
        logic [TRI_W-1:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) d = {d[TRI_W-33:0], 32'($urandom())};
        return d;
    endfunction

    task automatic pulse_start();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    // Present a triangle, wait (bounded) for the dispatcher to take it, optionally hold valid one extra cycle.
    task automatic send_tri(input logic [TRI_W-1:0] d, input bit two_cycle);
        int n;
        n = 0;
        i_tri_valid = 1'b1;
        i_tri_data  = d;
        while (o_tri_busy && n < 50) begin
            tick();
            n++;
        end
        check("accept_wait", TRI_W'(n < 50), 1);
        tick();
        if (two_cycle) tick();
        i_tri_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TRI_W-1:0] d [8];
        bit               flag;
        int               n;
        int               qs;
        logic [15:0]      exp_cnt [4];

        // Reset values
        ticks(2);
        check("rst_busy",   o_tri_busy,     1);
        check("rst_valid",  o_rast_valid,   0);
        check("rst_data",   o_rast_data,    0);
        check("rst_active", o_frame_active, 0);
        check("rst_done",   o_frame_done,   0);
        check("rst_count",  o_tri_count,    0);
        i_rst_n = 1'b1;
        tick();

        // Valid in IDLE is never accepted
        i_tri_valid = 1'b1;
        i_tri_data  = make_tri();
        ticks(4);
        check("idle_busy", o_tri_busy, 1);
        i_tri_valid = 1'b0;
        ticks(3);
        check("idle_no_issue", issue_q.size(), 0);

        // Three triangles, spaced, units idle: 0,1,0
        pulse_start();
        check("t1_active", o_frame_active, 1);
        check("t1_count0", o_tri_count,    0);
        check("t1_busy0",  o_tri_busy,     0);
        for (int i = 0; i < 3; i++) begin
            d[i] = make_tri();
            send_tri(d[i], 1'b0);
            ticks(10);
        end
        check("t1_issues", issue_q.size(), 3);
        check("t1_unit0",  issue_q[0], 2'b01);
        check("t1_unit1",  issue_q[1], 2'b10);
        check("t1_unit2",  issue_q[2], 2'b01);
        check("t1_data0",  data_q[0], d[0]);
        check("t1_data1",  data_q[1], d[1]);
        check("t1_data2",  data_q[2], d[2]);
        check("t1_count",  o_tri_count, 3);

        // Valid held two cycles per triangle: one accept each
        for (int i = 3; i < 5; i++) begin
            d[i] = make_tri();
            send_tri(d[i], 1'b1);
            ticks(10);
        end
        check("t2_issues", issue_q.size(), 5);
        check("t2_unit3",  issue_q[3], 2'b10);
        check("t2_unit4",  issue_q[4], 2'b01);
        check("t2_data3",  data_q[3], d[3]);
        check("t2_data4",  data_q[4], d[4]);
        check("t2_count",  o_tri_count, 5);

        // All units busy while a triangle is held
        force_busy = 2'b11;
        d[5] = make_tri();
        send_tri(d[5], 1'b0);
        flag = 1'b0;
        repeat (5) begin
            tick();
            if (!o_tri_busy) flag = 1'b1;
        end
        check("t3_busy_held", flag, 0);
        check("t3_no_issue",  issue_q.size(), 5);
        force_busy = 2'b01;
        tick();
        check("t3_valid", o_rast_valid, 2'b10);
        check("t3_data",  o_rast_data,  d[5]);
        force_busy = 2'b00;
        tick();
        check("t3_pulse_one", o_rast_valid, 0);
        check("t3_count",     o_tri_count,  6);

        // Drain with unit 0 busy for 20 cycles
        ticks(4);
        force_busy = 2'b01;
        i_vtx_done = 1'b1;
        flag = 1'b0;
        repeat (20) begin
            tick();
            if (o_frame_done) flag = 1'b1;
        end
        check("t4_no_early_done", flag,           0);
        check("t4_active_held",   o_frame_active, 1);
        force_busy = 2'b00;
        tick();
        check("t4_done",       o_frame_done,   1);
        check("t4_active_low", o_frame_active, 0);
        tick();
        check("t4_done_pulse", o_frame_done, 0);
        check("t4_count_kept", o_tri_count,  6);
        i_vtx_done = 1'b0;

        // Drain with idle units: DRAIN entry, four quiet cycles, then DONE
        pulse_start();
        check("t4b_count_clr", o_tri_count, 0);
        i_vtx_done = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_frame_done && n < 30);
        check("t4b_quiet_latency", n, 6);
        i_vtx_done = 1'b0;
        tick();

        // Asynchronous reset while a triangle is held
        pulse_start();
        force_busy = 2'b11;
        d[6] = make_tri();
        send_tri(d[6], 1'b0);
        ticks(2);
        check("t5_held_busy", o_tri_busy, 1);
        qs = issue_q.size();
        #1 i_rst_n = 1'b0;
        #1;
        check("t5_rst_busy",   o_tri_busy,     1);
        check("t5_rst_valid",  o_rast_valid,   0);
        check("t5_rst_data",   o_rast_data,    0);
        check("t5_rst_active", o_frame_active, 0);
        check("t5_rst_count",  o_tri_count,    0);
        ticks(2);
        force_busy = 2'b00;
        i_rst_n = 1'b1;
        ticks(5);
        check("t5_no_issue",  issue_q.size(), qs);
        check("t5_idle_busy", o_tri_busy,     1);

        // Count saturation from a preloaded value; mid-frame start ignored
        pulse_start();
        force dut.o_tri_count = 16'hFFFD;
        #1;
        release dut.o_tri_count;
        exp_cnt[0] = 16'hFFFE;
        exp_cnt[1] = 16'hFFFF;
        exp_cnt[2] = 16'hFFFF;
        exp_cnt[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            send_tri(make_tri(), 1'b0);
            ticks(4);
            check($sformatf("t6_count%0d", i), o_tri_count, exp_cnt[i]);
            if (i == 1) begin
                pulse_start();
                check("t6_start_ignored_active", o_frame_active, 1);
                check("t6_start_ignored_count",  o_tri_count,    16'hFFFF);
            end
        end
        i_vtx_done = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_frame_done && n < 30);
        check("t6_done_seen", o_frame_done, 1);
        check("t6_count_done", o_tri_count, 16'hFFFF);
        i_vtx_done = 1'b0;
        ticks(2);
        check("t6_count_idle", o_tri_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
